seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive side of the scanned seven-segment display bus; hex-to-7-seg encoders plus a digit scanner drive the transmit side.
//  Samples segment and anode lines, filters glitches, decodes each digit's pattern back to a 4-bit hex value.
//  Reconstructs the full multi-digit value; used for display loopback checking and board self-test.
// PARAMETERS
//  NUM_DIGITS        4   number of scanned digits (anode lines), 2..8
//  STABLE_CYCLES     4   consecutive identical samples required to accept a digit, 2..255
//  ANODE_ACTIVE_LOW  1   1: an_in bit = 0 selects digit; 0: bit = 1 selects digit
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               synchronous reset, active-high
//  seg_in       in   7               segment lines, active-high, bit0=a .. bit6=g
//  an_in        in   NUM_DIGITS      anode lines; bit i selects digit i (digit 0 = least significant nibble)
//  digits_out   out  4*NUM_DIGITS    decoded value; digit i in [4i+3:4i]
//  digit_valid  out  NUM_DIGITS      bit i = 1: digit i holds a valid decode since the last reset or error
//  frame_valid  out  1               1-cycle pulse: every digit accepted at least once since the previous pulse or reset
//  decode_err   out  1               1-cycle pulse: accepted pattern is not one of the 16 hex codes
//  err_digit    out  3               index of the digit that caused the last decode_err; held until next error
// BEHAVIOUR
//  Reset: all outputs 0; internal sample regs, counter and seen-mask 0; FSM enters BLANK.
//  Input stage: seg_in/an_in registered once (s_seg/s_an); all logic below uses the registered copies.
//  Digit select: s_an normalised by ANODE_ACTIVE_LOW; valid only if exactly one bit is active (one-hot).
//  Code table (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
//  FSM states:
//   BLANK  : select not one-hot; cnt=0. -> TRACK when select is one-hot (cnt=1).
//   TRACK  : if (s_an,s_seg) equal previous sample, cnt++; if they differ but remain one-hot, cnt=1 (stay);
//            if not one-hot, -> BLANK. When cnt reaches STABLE_CYCLES: perform ACCEPT, -> LOCKED.
//   LOCKED : digit already accepted for this dwell; no further accepts while (s_an,s_seg) is unchanged.
//            On change: one-hot -> TRACK with cnt=1; not one-hot -> BLANK.
//  ACCEPT, on match with hex code h for digit i: digits_out[4i+3:4i] <= h; digit_valid[i] <= 1; seen[i] <= 1.
//  ACCEPT, on no match: decode_err pulse; err_digit <= i; digit_valid[i] <= 0; nibble i is unchanged; seen unaffected.
//  frame_valid: when an accept makes seen all-ones, pulse frame_valid on the same edge the nibble updates; seen <= 0 on that edge.
//  Latency: with pins stable from sample edge E0, outputs update at edge E0+STABLE_CYCLES.
//   That is STABLE_CYCLES+1 edges after the pins change, including the input register.
//  Glitch: a pattern held for fewer than STABLE_CYCLES samples never updates any output.
//  Blank or overlap: all-inactive or multi-active anodes are ignored and break the current dwell.
//  Re-accepting the same digit with the same value is allowed; the write is idempotent and still sets seen.
//  Counter saturates at STABLE_CYCLES; no wrap.
//  Reset mid-dwell: everything clears; a pattern already on the pins needs a full STABLE_CYCLES from the first post-reset sample.
//  At most one accept per cycle; frame_valid and decode_err can never both assert from a single accept.
// TESTING (defaults: NUM_DIGITS=4, STABLE_CYCLES=4, anodes active-low)
//  1. an_in=4'b1011, seg_in=7'h4F held 6 cycles -> digits_out[11:8]=3, digit_valid=4'b0100, no pulses,
//     update exactly 5 edges after the pins change.
//  2. an_in=4'b1110, seg_in=7'h06 for 3 cycles, then an_in=4'b1111 -> digits_out, digit_valid and pulses all remain 0.
//  3. an_in=4'b0111, seg_in=7'h00 held 6 cycles -> one decode_err pulse, err_digit=3, digit_valid[3]=0;
//     holding longer gives no second pulse.
//  4. Scan digits 0..3 with codes 06,5B,4F,66, 5 cycles each plus 1 blank cycle between
//     -> digits_out=16'h4321, digit_valid=4'hF, single frame_valid on the digit-3 accept.
//  5. an_in=4'b1100 (two active) with seg_in=7'h7F for 10 cycles -> no accept, all outputs unchanged.
//  6. Assert rst after 2 cycles of a valid dwell, hold the pattern -> outputs 0 during reset;
//     accept occurs STABLE_CYCLES samples after rst drops.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receive side of a scanned seven-segment display bus.
// Samples segment/anode lines, filters glitches by requiring a stable dwell,
// decodes each digit back to hex and rebuilds the multi-digit value.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned STABLE_CYCLES    = 4,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    output logic [4*NUM_DIGITS-1:0]   digits_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic                      decode_err,
    output logic [2:0]                err_digit
);

    typedef enum logic [1:0] {BLANK, TRACK, LOCKED} state_t;

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [6:0]                s_seg_q, prev_seg_q;
    logic [NUM_DIGITS-1:0]     s_an_q, prev_an_q;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]     valid_q, valid_d;
    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic                      frame_q, frame_d;
    logic                      err_q, err_d;
    logic [2:0]                err_digit_q, err_digit_d;

    logic [NUM_DIGITS-1:0]     sel;
    logic [NUM_DIGITS-1:0]     seen_new;
    logic                      one_hot;
    logic                      changed;
    logic                      accept;
    logic [2:0]                idx;
    logic [3:0]                hex_val;
    logic                      hex_ok;
    int unsigned               ones;

    // Normalise anode polarity, check one-hot and find the selected digit index
    always_comb begin
        sel  = ANODE_ACTIVE_LOW ? ~s_an_q : s_an_q;
        ones = 0;
        idx  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                ones = ones + 1;
                idx  = i[2:0];
            end
        end
        one_hot = (ones == 1);
        changed = (s_an_q != prev_an_q) || (s_seg_q != prev_seg_q);
    end

    // Map a gfedcba pattern back to its hex value
    always_comb begin
        hex_ok  = 1'b1;
        hex_val = '0;
        case (s_seg_q)
            7'h3F: hex_val = 4'h0;
            7'h06: hex_val = 4'h1;
            7'h5B: hex_val = 4'h2;
            7'h4F: hex_val = 4'h3;
            7'h66: hex_val = 4'h4;
            7'h6D: hex_val = 4'h5;
            7'h7D: hex_val = 4'h6;
            7'h07: hex_val = 4'h7;
            7'h7F: hex_val = 4'h8;
            7'h6F: hex_val = 4'h9;
            7'h77: hex_val = 4'hA;
            7'h7C: hex_val = 4'hB;
            7'h39: hex_val = 4'hC;
            7'h5E: hex_val = 4'hD;
            7'h79: hex_val = 4'hE;
            7'h71: hex_val = 4'hF;
            default: hex_ok = 1'b0;
        endcase
    end

    // Dwell tracking FSM: next state, counter and accept strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            BLANK: begin
                if (one_hot) begin
                    state_d = TRACK;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = '0;
                end
            end
            TRACK: begin
                if (!one_hot) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end else begin
                    if (changed) begin
                        cnt_d = 8'd1;
                    end else if (cnt_q < STABLE_CNT) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cnt_d == STABLE_CNT) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (changed) begin
                    if (one_hot) begin
                        state_d = TRACK;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Accept handling: nibble write, valid/seen bookkeeping, frame and error pulses
    always_comb begin
        digits_d    = digits_q;
        valid_d     = valid_q;
        seen_d      = seen_q;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        seen_new    = seen_q | sel;
        if (accept) begin
            if (hex_ok) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        digits_d[4*i +: 4] = hex_val;
                    end
                end
                valid_d = valid_q | sel;
                if (seen_new == '1) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d  = seen_new;
                end
            end else begin
                err_d       = 1'b1;
                err_digit_d = idx;
                valid_d     = valid_q & ~sel;
            end
        end
    end

    // State, input sample and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            s_seg_q     <= '0;
            s_an_q      <= '0;
            prev_seg_q  <= '0;
            prev_an_q   <= '0;
            digits_q    <= '0;
            valid_q     <= '0;
            seen_q      <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_seg_q     <= seg_in;
            s_an_q      <= an_in;
            prev_seg_q  <= s_seg_q;
            prev_an_q   <= s_an_q;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign decode_err  = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with default parameters.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        decode_err;
    logic [2:0]  err_digit;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    seg7_scan_decoder #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(4),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .an_in(an_in),
        .digits_out(digits_out),
        .digit_valid(digit_valid),
        .frame_valid(frame_valid),
        .decode_err(decode_err),
        .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge
    always @(negedge clk) begin
        if (frame_valid) frame_cnt++;
        if (decode_err)  err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        an_in  = an;
        seg_in = seg;
    endtask

    initial begin
        // Reset state
        tick(3);
        check_eq("rst_digits", 32'(digits_out), 32'h0);
        check_eq("rst_valid", 32'(digit_valid), 32'h0);
        check_eq("rst_frame", 32'(frame_valid), 32'h0);
        check_eq("rst_err", 32'(decode_err), 32'h0);
        check_eq("rst_err_digit", 32'(err_digit), 32'h0);
        rst = 1'b0;
        tick(2);

        // 1: digit 2 shows '3', update exactly 5 edges after pin change
        drive(4'b1011, 7'h4F);
        tick(4);
        check_eq("t1_not_yet", 32'(digit_valid), 32'h0);
        tick(1);
        check_eq("t1_nibble", 32'(digits_out[11:8]), 32'h3);
        check_eq("t1_valid", 32'(digit_valid), 32'h4);
        tick(1);
        check_eq("t1_frames", 32'(frame_cnt), 32'h0);
        check_eq("t1_errs", 32'(err_cnt), 32'h0);
        drive(4'b1111, 7'h00);
        tick(2);

        // 2: glitch of 3 samples on digit 0 never lands
        drive(4'b1110, 7'h06);
        tick(3);
        drive(4'b1111, 7'h06);
        tick(6);
        check_eq("t2_digits", 32'(digits_out), 32'h0300);
        check_eq("t2_valid", 32'(digit_valid), 32'h4);
        check_eq("t2_pulses", 32'(frame_cnt + err_cnt), 32'h0);

        // 3: blank pattern on digit 3 is a decode error, reported once
        drive(4'b0111, 7'h00);
        tick(4);
        check_eq("t3_err_early", 32'(decode_err), 32'h0);
        tick(1);
        check_eq("t3_err_pulse", 32'(decode_err), 32'h1);
        check_eq("t3_err_digit", 32'(err_digit), 32'h3);
        tick(1);
        check_eq("t3_err_single", 32'(decode_err), 32'h0);
        tick(4);
        check_eq("t3_err_cnt", 32'(err_cnt), 32'h1);
        check_eq("t3_valid", 32'(digit_valid), 32'h4);
        check_eq("t3_digits", 32'(digits_out), 32'h0300);
        drive(4'b1111, 7'h00);
        tick(1);

        // 4: full scan 1,2,3,4 -> 0x4321 with one frame pulse on digit 3
        drive(4'b1110, 7'h06); tick(5); drive(4'b1111, 7'h00); tick(1);
        drive(4'b1101, 7'h5B); tick(5); drive(4'b1111, 7'h00); tick(1);
        drive(4'b1011, 7'h4F); tick(5); drive(4'b1111, 7'h00); tick(1);
        check_eq("t4_no_frame_yet", 32'(frame_cnt), 32'h0);
        drive(4'b0111, 7'h66); tick(5);
        check_eq("t4_frame_pulse", 32'(frame_valid), 32'h1);
        drive(4'b1111, 7'h00); tick(1);
        check_eq("t4_digits", 32'(digits_out), 32'h4321);
        check_eq("t4_valid", 32'(digit_valid), 32'hF);
        check_eq("t4_frame_cnt", 32'(frame_cnt), 32'h1);
        check_eq("t4_err_cnt", 32'(err_cnt), 32'h1);
        check_eq("t4_err_digit_held", 32'(err_digit), 32'h3);

        // 5: overlapping anodes are ignored
        drive(4'b1100, 7'h7F);
        tick(10);
        check_eq("t5_digits", 32'(digits_out), 32'h4321);
        check_eq("t5_valid", 32'(digit_valid), 32'hF);
        check_eq("t5_pulses", 32'(frame_cnt + err_cnt), 32'h2);
        drive(4'b1111, 7'h00);
        tick(1);

        // 6: reset mid-dwell, then full dwell after release
        drive(4'b1101, 7'h7D);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_eq("t6_rst_digits", 32'(digits_out), 32'h0);
        check_eq("t6_rst_valid", 32'(digit_valid), 32'h0);
        check_eq("t6_rst_err_digit", 32'(err_digit), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(4);
        check_eq("t6_not_yet", 32'(digit_valid), 32'h0);
        tick(1);
        check_eq("t6_digits", 32'(digits_out), 32'h0060);
        check_eq("t6_valid", 32'(digit_valid), 32'h2);
        tick(2);
        check_eq("t6_pulses", 32'(frame_cnt + err_cnt), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
